ma216_audio_out: RTL and testbench
==================================

Name: ma216_audio_out

Overview:
Post-processing stage directly downstream of the MA216 sound board's 8-bit unsigned mixed audio output.
- Decimates the per-clk audio stream to a fixed sample rate by box-car averaging.
- Centres it to signed, applies a one-pole low-pass, removes DC, applies 4-bit volume/mute and saturates.
- Delivers a 16-bit signed sample with a one-cycle valid strobe to the framework audio mixer.

Parameters:
DECIM, 64, clk cycles per output sample; power of two, 8..1024.
LP_SHIFT, 2, low-pass coefficient 2^-LP_SHIFT (0 = bypass).
HP_SHIFT, 8, DC-tracker coefficient 2^-HP_SHIFT.

Ports:
clk  input  1  system clock; same clk as the sound board.
reset  input  1  synchronous, active-high reset.
audio_in  input  8  unsigned board audio; 128 = silence.
volume  input  4  gain = volume/8; 8 = unity, 0 = silent, 15 = 1.875.
mute  input  1  forces output samples to 0.
sample  output  16  signed output sample; holds between strobes.
sample_valid  output  1  one-cycle pulse when sample updates.

Behaviour:
- Reset: clears phase counter, accumulator, all pipeline registers, lp state, dc state and valids. sample=0, sample_valid=0.
- Reset mid-operation discards any partial sum and in-flight samples; timing restarts from cycle 0.
- Cycle indexing: cycle 0 is the first cycle with reset low.
- Stage 0, decimation:
  - phase counts 0..DECIM-1, wraps to 0. acc (8+log2 DECIM bits) adds audio_in every cycle.
  - At phase DECIM-1: avg <= (acc+audio_in)>>log2(DECIM), acc <= 0, v1 <= 1.
  - No overflow is possible: max avg = 255.
- Stage 1: s <= {avg,8'h00} - 16'h8000 (signed). avg 128 -> 0, avg 255 -> 32512, avg 0 -> -32768.
- Stage 2: lp <= lp + ((s-lp)>>>LP_SHIFT). Difference is 17-bit signed; arithmetic shift; result always lies between lp and s, so it fits in 16 bits.
- Stage 3:
  - hp <= lp - dc (17-bit signed), using the pre-update dc.
  - dc <= dc + ((lp-dc)>>>HP_SHIFT).
- Stage 4:
  - p = hp * {1'b0,volume} (22-bit signed); q = p>>>3.
  - Saturate q to [-32768, 32767].
  - sample <= mute ? 0 : sat(q). mute and volume are sampled at this stage only.
  - sample_valid <= 1 for exactly one cycle.
- Each stage advances only on its valid; otherwise it holds state.
- Latency: first sample_valid in cycle DECIM+4, then exactly every DECIM cycles. Never two pulses closer than DECIM.
- Filter state (lp, dc) updates even when mute=1 or volume=0, so unmuting is click-consistent.
- Volume/mute changes between strobes take effect on the next stage-4 update; there is no glitch on sample.

Decomposition:
- Package ma216_audio_pkg holds:
  - SAMPLE_W=16, GAIN_UNITY=4'd8, GAIN_FRAC=3.
  - SAT_MAX=16'sh7FFF, SAT_MIN=16'sh8000.
  - Silence code 8'd128.
- Sub-module ma216_onepole: valid-gated shift-coefficient one-pole filter with output y, parameter SHIFT. Two instances:
  - Stage 2, SHIFT=LP_SHIFT, fed s.
  - Stage 3 dc tracker, SHIFT=HP_SHIFT, fed lp.
  - The top level forms hp from its pre-update output.

Test Plan:
- Reset, audio_in=128, volume=8, mute=0, 1000 cycles -> first sample_valid in cycle 68; pulses every 64 cycles; every sample=0.
- audio_in step 128->255 from cycle 0, volume=8 -> first sample=8128. Second: lp=14224, dc=31, sample=14193. Thereafter sample decays toward 0 as dc converges.
- LP_SHIFT=0, audio_in=255, volume=15 -> first sample=32767 (saturated from 60960). audio_in=0 -> first sample=-32768.
- audio_in alternating 0/255 each cycle starting with 0 -> avg=127, s=-256. Proves averaging rather than point sampling.
- Step to 255 with mute=1 -> samples all 0. Drop mute just before the 3rd strobe -> 3rd sample equals the unmuted-reference 3rd value (filter kept running).
- Assert reset at phase 40, hold 3 cycles, release -> no sample_valid until 68 cycles after release; first sample computed from post-reset input only.

Source files
------------

// File: rtl/ma216_audio_pkg.sv
// Shared widths, gain/saturation constants and helpers for the MA216 audio post-processing path.
package ma216_audio_pkg;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned AUDIO_W    = 8;
  localparam int unsigned VOL_W      = 4;
  localparam int unsigned WIDE_W     = SAMPLE_W + 1;
  localparam int unsigned PROD_W     = WIDE_W + VOL_W + 1;

  localparam logic [VOL_W-1:0] GAIN_UNITY = 4'd8;
  localparam int unsigned      GAIN_FRAC  = $clog2(GAIN_UNITY);

  localparam logic signed [SAMPLE_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAT_MIN = 16'sh8000;

  localparam logic [AUDIO_W-1:0] SILENCE = 8'd128;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [WIDE_W-1:0]   wide_t;
  typedef logic signed [PROD_W-1:0]   prod_t;

  // Clamp a scaled product into the signed 16-bit output range.
  function automatic sample_t sat_sample(input prod_t v);
    if (v > PROD_W'(SAT_MAX)) begin
      return SAT_MAX;
    end else if (v < PROD_W'(SAT_MIN)) begin
      return SAT_MIN;
    end
    return SAMPLE_W'(v);
  endfunction

endpackage

// File: rtl/ma216_audio_out_onepole.sv
// Valid-gated one-pole filter: y += (x - y) >>> SHIFT on each valid; holds otherwise.
module ma216_onepole
  import ma216_audio_pkg::*;
#(
  parameter int unsigned SHIFT = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_i,
  input  logic signed [SAMPLE_W-1:0] x_i,
  output logic signed [SAMPLE_W-1:0] y_o
);

  sample_t y_q, y_d;
  wide_t   diff_c, step_c, sum_c;

  // The new value lies between y and x, so truncating the 17-bit sum is exact.
  always_comb begin
    diff_c = WIDE_W'(x_i) - WIDE_W'(y_q);
    step_c = diff_c >>> SHIFT;
    sum_c  = WIDE_W'(y_q) + step_c;
    y_d    = y_q;
    if (valid_i) begin
      y_d = SAMPLE_W'(sum_c);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/ma216_audio_out.sv
// MA216 audio output stage: box-car decimation, centring, low-pass, DC removal,
// volume/mute and saturation to a 16-bit signed sample with a one-cycle strobe.
module ma216_audio_out
  import ma216_audio_pkg::*;
#(
  parameter int unsigned DECIM    = 64,
  parameter int unsigned LP_SHIFT = 2,
  parameter int unsigned HP_SHIFT = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [AUDIO_W-1:0]         audio_in,
  input  logic [VOL_W-1:0]           volume,
  input  logic                       mute,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_valid
);

  localparam int unsigned PH_W  = $clog2(DECIM);
  localparam int unsigned ACC_W = AUDIO_W + PH_W;

  logic [PH_W-1:0]    phase_q, phase_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_sum_c;
  logic [AUDIO_W-1:0] avg_q, avg_d;
  logic               v1_q, v1_d;
  sample_t            s_q, s_d;
  logic               v2_q, v2_d;
  sample_t            lp_y;
  logic               v3_q, v3_d;
  sample_t            dc_y;
  wide_t              hp_q, hp_d;
  logic               v4_q, v4_d;
  prod_t              prod_c, gain_c;
  sample_t            sample_q, sample_d;
  logic               valid_q, valid_d;

  // Stage 0: accumulate DECIM inputs, emit their mean on the last phase.
  always_comb begin
    phase_d   = phase_q + PH_W'(1);
    acc_sum_c = acc_q + ACC_W'(audio_in);
    acc_d     = acc_sum_c;
    avg_d     = avg_q;
    v1_d      = 1'b0;
    if (phase_q == PH_W'(DECIM - 1)) begin
      avg_d = AUDIO_W'(acc_sum_c >> PH_W);
      acc_d = '0;
      v1_d  = 1'b1;
    end
  end

  // Stage 1: re-centre unsigned average around zero.
  always_comb begin
    s_d  = s_q;
    v2_d = v1_q;
    if (v1_q) begin
      s_d = sample_t'({avg_q, 8'h00}) - sample_t'({SILENCE, 8'h00});
    end
  end

  ma216_onepole #(
    .SHIFT (LP_SHIFT)
  ) u_lp (
    .clk     (clk),
    .reset   (reset),
    .valid_i (v2_q),
    .x_i     (s_q),
    .y_o     (lp_y)
  );

  ma216_onepole #(
    .SHIFT (HP_SHIFT)
  ) u_dc (
    .clk     (clk),
    .reset   (reset),
    .valid_i (v3_q),
    .x_i     (lp_y),
    .y_o     (dc_y)
  );

  // Stage 3: high-pass uses the DC estimate from before this update.
  always_comb begin
    v3_d = v2_q;
    v4_d = v3_q;
    hp_d = hp_q;
    if (v3_q) begin
      hp_d = WIDE_W'(lp_y) - WIDE_W'(dc_y);
    end
  end

  // Stage 4: volume/mute are only looked at here, so changes never glitch the held sample.
  always_comb begin
    prod_c   = PROD_W'(hp_q) * PROD_W'(signed'({1'b0, volume}));
    gain_c   = prod_c >>> GAIN_FRAC;
    sample_d = sample_q;
    valid_d  = v4_q;
    if (v4_q) begin
      sample_d = mute ? '0 : sat_sample(gain_c);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= '0;
      acc_q    <= '0;
      avg_q    <= '0;
      v1_q     <= 1'b0;
      s_q      <= '0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      hp_q     <= '0;
      v4_q     <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      acc_q    <= acc_d;
      avg_q    <= avg_d;
      v1_q     <= v1_d;
      s_q      <= s_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      hp_q     <= hp_d;
      v4_q     <= v4_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_ma216_audio_out.sv
// Bench for ma216_audio_out: two instances (LP_SHIFT 2 and 0) against a window-level arithmetic model.
module tb_ma216_audio_out;

  localparam int DECIM = 64;
  localparam int HP    = 8;
  localparam int LP_A  = 2;
  localparam int LP_B  = 0;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        audio_in;
  logic [3:0]        volume;
  logic              mute;
  logic signed [15:0] sample_a, sample_b;
  logic              valid_a, valid_b;

  ma216_audio_out #(.DECIM(DECIM), .LP_SHIFT(LP_A), .HP_SHIFT(HP)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .audio_in     (audio_in),
    .volume       (volume),
    .mute         (mute),
    .sample       (sample_a),
    .sample_valid (valid_a)
  );

  ma216_audio_out #(.DECIM(DECIM), .LP_SHIFT(LP_B), .HP_SHIFT(HP)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .audio_in     (audio_in),
    .volume       (volume),
    .mute         (mute),
    .sample       (sample_b),
    .sample_valid (valid_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: whole-window average, then filter arithmetic on plain ints.
  typedef struct {
    int due;
    int hp_a;
    int hp_b;
  } pend_t;

  pend_t pend[$];
  int    sum, cyc, lp_a, lp_b, dc_a, dc_b, exp_a, exp_b, first_a;
  bit    exp_v;
  int    cap_a[$];
  int    cap_b[$];

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic tick(input bit rst, input int a, input int v, input bit m);
    int    avg;
    int    s;
    pend_t p;
    reset    = rst;
    audio_in = 8'(a);
    volume   = 4'(v);
    mute     = m;
    @(posedge clk);
    if (rst) begin
      sum = 0; cyc = 0; lp_a = 0; lp_b = 0; dc_a = 0; dc_b = 0;
      exp_a = 0; exp_b = 0; exp_v = 0; first_a = -1;
      pend.delete();
      cap_a.delete();
      cap_b.delete();
    end else begin
      sum += a;
      if (cyc % DECIM == DECIM - 1) begin
        avg = sum / DECIM;
        sum = 0;
        s = avg * 256 - 32768;
        lp_a += (s - lp_a) >>> LP_A;
        lp_b += (s - lp_b) >>> LP_B;
        p.due  = cyc + 4;
        p.hp_a = lp_a - dc_a;
        p.hp_b = lp_b - dc_b;
        dc_a += (lp_a - dc_a) >>> HP;
        dc_b += (lp_b - dc_b) >>> HP;
        pend.push_back(p);
      end
      exp_v = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        exp_v = 1;
        exp_a = m ? 0 : sat16((pend[0].hp_a * v) >>> 3);
        exp_b = m ? 0 : sat16((pend[0].hp_b * v) >>> 3);
        void'(pend.pop_front());
      end
      cyc++;
    end
    @(negedge clk);
    chk("valid_a", 32'(valid_a), 32'(exp_v));
    chk("sample_a", 32'(sample_a), exp_a);
    chk("valid_b", 32'(valid_b), 32'(exp_v));
    chk("sample_b", 32'(sample_b), exp_b);
    if (!rst) begin
      if (valid_a) cap_a.push_back(int'(sample_a));
      if (valid_b) cap_b.push_back(int'(sample_b));
      if (valid_a && first_a < 0) first_a = cyc;
    end
  endtask

  task automatic do_reset(input int n);
    repeat (n) tick(1'b1, 128, 8, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int lo, hi, vol;
    bit m;

    do_reset(2);

    // Silence: pulses start at cycle 68 and repeat every 64.
    for (int i = 0; i < 1000; i++) tick(1'b0, 128, 8, 1'b0);
    chk("lat_silence", first_a, 68);
    chk("cnt_silence", cap_a.size(), 15);

    // Step to full scale at unity gain.
    do_reset(1);
    for (int i = 0; i < 300; i++) tick(1'b0, 255, 8, 1'b0);
    chk("step_a1", cap_a.size() > 0 ? cap_a[0] : -99999, 8128);
    chk("step_a2", cap_a.size() > 1 ? cap_a[1] : -99999, 14193);
    chk("step_b1", cap_b.size() > 0 ? cap_b[0] : -99999, 32512);

    // Saturation with the low-pass bypassed.
    do_reset(1);
    for (int i = 0; i < 100; i++) tick(1'b0, 255, 15, 1'b0);
    chk("sat_hi", cap_b.size() > 0 ? cap_b[0] : -99999, 32767);
    do_reset(1);
    for (int i = 0; i < 100; i++) tick(1'b0, 0, 15, 1'b0);
    chk("sat_lo", cap_b.size() > 0 ? cap_b[0] : -99999, -32768);

    // Alternating 0/255: averaging gives 127, not a point sample.
    do_reset(1);
    for (int i = 0; i < 100; i++) tick(1'b0, (i % 2) ? 255 : 0, 8, 1'b0);
    chk("alt_b", cap_b.size() > 0 ? cap_b[0] : -99999, -256);
    chk("alt_a", cap_a.size() > 0 ? cap_a[0] : -99999, -64);

    // Muted step, unmuted before the third strobe.
    do_reset(1);
    for (int i = 0; i < 260; i++) tick(1'b0, 255, 8, i < 190);
    chk("mute_1", cap_a.size() > 0 ? cap_a[0] : -99999, 0);
    chk("mute_2", cap_a.size() > 1 ? cap_a[1] : -99999, 0);
    chk("mute_3", cap_a.size() > 2 ? cap_a[2] : -99999, 18710);

    // Reset at phase 40 for 3 cycles: partial sum of 255s must be lost.
    do_reset(1);
    for (int i = 0; i < 40; i++) tick(1'b0, 255, 8, 1'b0);
    do_reset(3);
    for (int i = 0; i < 200; i++) tick(1'b0, 0, 8, 1'b0);
    chk("lat_rst", first_a, 68);
    chk("rst_a1", cap_a.size() > 0 ? cap_a[0] : -99999, -8192);

    // Randomised segments of input range, volume, mute and rare resets.
    do_reset(1);
    vol = 8;
    m   = 1'b0;
    lo  = 0;
    hi  = 255;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        lo = $urandom_range(0, 255);
        hi = $urandom_range(lo, 255);
      end
      if ($urandom_range(0, 39) == 0) vol = $urandom_range(0, 15);
      if ($urandom_range(0, 99) == 0) m = ~m;
      if ($urandom_range(0, 999) == 0) tick(1'b1, 128, vol, m);
      else tick(1'b0, $urandom_range(lo, hi), vol, m);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
